mux_sel_skid: RTL and testbench

Parametrised N-input word multiplexer with a registered 2-entry skid-buffer output stage and valid/ready handshakes. It generalises the 32-bit 3-to-1 operand mux used in the datapath. Its main use is to select an ALU or forwarding operand per beat and launch it into the next pipeline stage, absorbing one cycle of downstream back-pressure without a combinational ready path. A synchronous flush discards in-flight beats on branch or exception.

---
 rtl/mux_sel_skid_if.sv | 29 ++
 rtl/mux_sel_skid.sv | 77 +++++++
 tb/tb_mux_sel_skid.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mux_sel_skid_if.sv
// Handshake bundle for mux_sel_skid: upstream beat (data/select/valid/ready),
// synchronous flush, and the downstream head-beat channel.
interface mux_sel_skid_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_bad;
  logic                    out_valid;
  logic                    out_ready;

  // Block side: consumes the upstream beat, produces the head beat.
  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_bad, out_valid
  );

  // Environment side: drives the upstream beat, observes the head beat.
  modport master (
    output in_data, in_sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_bad, out_valid
  );
endinterface

// File: rtl/mux_sel_skid.sv
// N-input word multiplexer feeding a 2-entry skid buffer. The main entry
// drives the outputs; the skid entry absorbs one beat of back-pressure so
// that in_ready comes straight from a flop and never from out_ready.
module mux_sel_skid #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  mux_sel_skid_if.slave   bus
);

  logic [WIDTH-1:0] r_main_data;
  logic             r_main_bad;
  logic             r_main_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_bad;
  logic             r_skid_valid;

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_bad;
  logic             w_acc;
  logic             w_pop;

  // Select the addressed input; out-of-range selects yield zero and flag bad.
  // The extra select bit keeps the compare correct when 2^SEL_W == NUM_IN.
  always_comb begin
    w_sel_data = '0;
    w_sel_bad  = ({1'b0, bus.in_sel} >= (SEL_W+1)'(NUM_IN));
    for (int k = 0; k < NUM_IN; k++) begin
      if ({1'b0, bus.in_sel} == (SEL_W+1)'(k)) begin
        w_sel_data = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_acc = bus.in_valid && !r_skid_valid;
  assign w_pop = r_main_valid && bus.out_ready;

  // Main/skid update, highest priority first: clear, refill from skid,
  // load main, park in skid, drain main.
  always_ff @(posedge i_clk) begin
    if (i_reset || bus.flush) begin
      r_main_data  <= '0;
      r_main_bad   <= 1'b0;
      r_main_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_bad   <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_pop && r_skid_valid) begin
      r_main_data  <= r_skid_data;
      r_main_bad   <= r_skid_bad;
      r_main_valid <= 1'b1;
      r_skid_data  <= '0;
      r_skid_bad   <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_acc && (!r_main_valid || w_pop)) begin
      r_main_data  <= w_sel_data;
      r_main_bad   <= w_sel_bad;
      r_main_valid <= 1'b1;
    end else if (w_acc) begin
      // Main is full and not draining: this beat waits in skid.
      r_skid_data  <= w_sel_data;
      r_skid_bad   <= w_sel_bad;
      r_skid_valid <= 1'b1;
    end else if (w_pop) begin
      r_main_valid <= 1'b0;
    end
  end

  assign bus.out_data  = r_main_data;
  assign bus.out_bad   = r_main_bad;
  assign bus.out_valid = r_main_valid;
  assign bus.in_ready  = !r_skid_valid;

endmodule

// File: tb/tb_mux_sel_skid.sv
// Directed bench for mux_sel_skid (32-bit, 3 inputs) plus a randomised
// valid/ready run on an 8-bit, 16-input instance against a queue model.
module tb_mux_sel_skid;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mux_sel_skid_if #(.WIDTH(32), .NUM_IN(3),  .SEL_W(2)) if0 ();
  mux_sel_skid_if #(.WIDTH(8),  .NUM_IN(16), .SEL_W(4)) if1 ();

  mux_sel_skid #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut0 (
    .i_clk(clk), .i_reset(rst), .bus(if0.slave)
  );
  mux_sel_skid #(.WIDTH(8), .NUM_IN(16), .SEL_W(4)) dut1 (
    .i_clk(clk), .i_reset(rst), .bus(if1.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out0(input string tag, input logic v, input logic [31:0] d,
                          input logic b, input logic rdy);
    chk({tag, "_valid"}, 64'(if0.out_valid), 64'(v));
    if (v) begin
      chk({tag, "_data"}, 64'(if0.out_data), 64'(d));
      chk({tag, "_bad"},  64'(if0.out_bad),  64'(b));
    end
    chk({tag, "_inrdy"}, 64'(if0.in_ready), 64'(rdy));
  endtask

  task automatic set_word(input logic [31:0] w);
    if0.in_data = {32'h33333333, 32'h22222222, w};
    if0.in_sel  = 2'd0;
  endtask

  logic [7:0] q[$];
  logic [7:0] bytes_r[16];
  logic       pre_acc, pre_pop;
  logic [7:0] pre_out, acc_word;

  initial begin
    if0.in_data   = {32'h33333333, 32'h22222222, 32'h11111111};
    if0.in_sel    = 2'd0;
    if0.in_valid  = 1'b1;
    if0.flush     = 1'b0;
    if0.out_ready = 1'b1;
    if1.in_data   = '0;
    if1.in_sel    = '0;
    if1.in_valid  = 1'b0;
    if1.flush     = 1'b0;
    if1.out_ready = 1'b1;

    // Reset held two cycles with in_valid high
    tick();
    chk("rst1_valid", 64'(if0.out_valid), 64'd0);
    chk("rst1_data",  64'(if0.out_data),  64'd0);
    chk("rst1_bad",   64'(if0.out_bad),   64'd0);
    chk("rst1_inrdy", 64'(if0.in_ready),  64'd1);
    tick();
    chk("rst2_valid", 64'(if0.out_valid), 64'd0);
    chk("rst2_data",  64'(if0.out_data),  64'd0);
    chk("rst2_inrdy", 64'(if0.in_ready),  64'd1);
    if0.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("idle_valid", 64'(if0.out_valid), 64'd0);
    chk("idle_inrdy", 64'(if0.in_ready),  64'd1);

    // Streaming select 0,1,2,1
    if0.in_valid = 1'b1;
    if0.in_sel = 2'd0; tick(); chk_out0("str0", 1, 32'h11111111, 0, 1);
    if0.in_sel = 2'd1; tick(); chk_out0("str1", 1, 32'h22222222, 0, 1);
    if0.in_sel = 2'd2; tick(); chk_out0("str2", 1, 32'h33333333, 0, 1);
    if0.in_sel = 2'd1; tick(); chk_out0("str3", 1, 32'h22222222, 0, 1);
    if0.in_valid = 1'b0;
    tick(); chk_out0("str_drain", 0, 32'h0, 0, 1);

    // Bad select then good select
    if0.in_valid = 1'b1;
    if0.in_sel = 2'd3; tick(); chk_out0("badsel", 1, 32'h00000000, 1, 1);
    if0.in_sel = 2'd0; tick(); chk_out0("goodsel", 1, 32'h11111111, 0, 1);
    if0.in_valid = 1'b0;
    tick(); chk_out0("bad_drain", 0, 32'h0, 0, 1);

    // Back-pressure: A shown, out_ready low 2 cycles, B parks in skid
    if0.in_valid = 1'b1;
    set_word(32'hAAAA0001); tick(); chk_out0("bp_a", 1, 32'hAAAA0001, 0, 1);
    if0.out_ready = 1'b0;
    set_word(32'hBBBB0002); tick(); chk_out0("bp_stall1", 1, 32'hAAAA0001, 0, 0);
    set_word(32'hCCCC0003); tick(); chk_out0("bp_stall2", 1, 32'hAAAA0001, 0, 0);
    if0.out_ready = 1'b1;
    tick(); chk_out0("bp_b", 1, 32'hBBBB0002, 0, 1);
    tick(); chk_out0("bp_c", 1, 32'hCCCC0003, 0, 1);
    set_word(32'hDDDD0004); tick(); chk_out0("bp_d", 1, 32'hDDDD0004, 0, 1);
    if0.in_valid = 1'b0;
    tick(); chk_out0("bp_drain", 0, 32'h0, 0, 1);

    // Flush with main and skid both full and a beat presented
    if0.out_ready = 1'b0;
    if0.in_valid  = 1'b1;
    set_word(32'hEEEE0005); tick(); chk_out0("fl_main", 1, 32'hEEEE0005, 0, 1);
    set_word(32'hFFFF0006); tick(); chk_out0("fl_skid", 1, 32'hEEEE0005, 0, 0);
    set_word(32'h99990007);
    if0.flush = 1'b1;
    tick();
    chk("fl_valid", 64'(if0.out_valid), 64'd0);
    chk("fl_data",  64'(if0.out_data),  64'd0);
    chk("fl_bad",   64'(if0.out_bad),   64'd0);
    chk("fl_inrdy", 64'(if0.in_ready),  64'd1);
    if0.flush = 1'b0;
    if0.in_valid = 1'b0;
    if0.out_ready = 1'b1;
    tick(); chk_out0("fl_after1", 0, 32'h0, 0, 1);
    tick(); chk_out0("fl_after2", 0, 32'h0, 0, 1);

    // Flush concurrent with an acceptable beat drops it
    if0.in_valid = 1'b1;
    if0.flush = 1'b1;
    set_word(32'h12345678); tick(); chk_out0("flacc", 0, 32'h0, 0, 1);
    if0.flush = 1'b0;
    if0.in_valid = 1'b0;
    tick(); chk_out0("flacc_after", 0, 32'h0, 0, 1);

    // Reset mid-transfer
    if0.in_valid = 1'b1;
    set_word(32'h0BADF00D); tick(); chk_out0("rmid_load", 1, 32'h0BADF00D, 0, 1);
    rst = 1'b1;
    tick();
    chk("rmid_valid", 64'(if0.out_valid), 64'd0);
    chk("rmid_data",  64'(if0.out_data),  64'd0);
    chk("rmid_inrdy", 64'(if0.in_ready),  64'd1);
    rst = 1'b0;
    if0.in_valid = 1'b0;
    tick();

    // Randomised valid/ready on the 16-input instance
    q.delete();
    for (int k = 0; k < 16; k++) bytes_r[k] = 8'($urandom);
    for (int k = 0; k < 16; k++) if1.in_data[k*8 +: 8] = bytes_r[k];
    if1.in_sel    = 4'($urandom_range(0, 15));
    if1.in_valid  = ($urandom_range(0, 3) != 0);
    if1.out_ready = ($urandom_range(0, 3) != 0);
    for (int it = 0; it < 400; it++) begin
      pre_acc  = if1.in_valid && if1.in_ready;
      pre_pop  = if1.out_valid && if1.out_ready;
      pre_out  = if1.out_data;
      acc_word = bytes_r[if1.in_sel];
      tick();
      if (pre_pop && q.size() > 0) begin
        chk("sweep_order", 64'(pre_out), 64'(q[0]));
        void'(q.pop_front());
      end
      if (pre_acc) q.push_back(acc_word);
      chk("sweep_valid", 64'(if1.out_valid), 64'(q.size() != 0));
      chk("sweep_inrdy", 64'(if1.in_ready),  64'(q.size() < 2));
      if (if1.out_valid && q.size() > 0) begin
        chk("sweep_data", 64'(if1.out_data), 64'(q[0]));
        chk("sweep_bad",  64'(if1.out_bad),  64'd0);
      end
      for (int k = 0; k < 16; k++) bytes_r[k] = 8'($urandom);
      for (int k = 0; k < 16; k++) if1.in_data[k*8 +: 8] = bytes_r[k];
      if1.in_sel    = 4'($urandom_range(0, 15));
      if1.in_valid  = ($urandom_range(0, 3) != 0);
      if1.out_ready = ($urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
